// File: rtl/riscv_dmem_wb_bridge_if.sv
// Wishbone classic bus between the data-side bridge (master) and a memory slave.
interface riscv_dmem_wb_bridge_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    modport master (
        output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        output dat_i, ack_i, err_i
    );
endinterface

// File: rtl/riscv_dmem_wb_bridge.sv
// Data-side bridge: one tagged load/store/flush/invalidate at a time, each load/store
// becomes a single Wishbone classic cycle guarded by a timeout.
module riscv_dmem_wb_bridge #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_rd_i,
    input  logic [3:0]  mem_wr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_wr_i,
    input  logic [10:0] mem_req_tag_i,
    input  logic        mem_cacheable_i,
    input  logic        mem_flush_i,
    input  logic        mem_invalidate_i,
    output logic        mem_accept_o,
    output logic        mem_ack_o,
    output logic        mem_error_o,
    output logic [31:0] mem_data_rd_o,
    output logic [10:0] mem_resp_tag_o,
    riscv_dmem_wb_bridge_if.master wb
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_CNT = TIMEOUT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_e;

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic [10:0]          tag_q, tag_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [10:0]          rtag_q, rtag_d;

    logic req;
    logic cache_op;
    logic is_store;
    logic timeout_hit;

    // The cache hint and the sub-word address bits have no meaning on a word-wide bus.
    logic unused_ok;
    assign unused_ok = mem_cacheable_i ^ mem_addr_i[1] ^ mem_addr_i[0];

    assign is_store    = |mem_wr_i;
    assign cache_op    = mem_flush_i | mem_invalidate_i;
    assign req         = mem_rd_i | is_store | cache_op;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT_CNT);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        tag_d   = tag_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        rtag_d  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    tag_d = mem_req_tag_i;
                    adr_d = {mem_addr_i[31:2], 2'b00};
                    dat_d = mem_data_wr_i;
                    if (cache_op) begin
                        // Maintenance ops have no bus side; answer straight away.
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        rtag_d  = mem_req_tag_i;
                    end else begin
                        we_d    = is_store;
                        sel_d   = is_store ? mem_wr_i : 4'hF;
                        cnt_d   = '0;
                        state_d = ST_BUS;
                    end
                end
            end

            ST_BUS: begin
                if (wb.err_i) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rtag_d  = tag_q;
                end else if (wb.ack_i) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    rdata_d = we_q ? 32'h0 : wb.dat_i;
                    rtag_d  = tag_q;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rtag_d  = tag_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            tag_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rtag_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            tag_q   <= tag_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rtag_q  <= rtag_d;
        end
    end

    assign mem_accept_o   = (state_q == ST_IDLE);
    assign mem_ack_o      = ack_q;
    assign mem_error_o    = err_q;
    assign mem_data_rd_o  = rdata_q;
    assign mem_resp_tag_o = rtag_q;

    assign wb.cyc_o = (state_q == ST_BUS);
    assign wb.stb_o = (state_q == ST_BUS);
    assign wb.we_o  = we_q;
    assign wb.sel_o = sel_q;
    assign wb.adr_o = adr_q;
    assign wb.dat_o = dat_q;

endmodule

// File: tb/tb_riscv_dmem_wb_bridge.sv
// Self-checking bench for riscv_dmem_wb_bridge: directed vector table, random traffic
// against a reference model, and hand-written reset / idle-ack sequences.
module tb_riscv_dmem_wb_bridge;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_rd_i;
    logic [3:0]  mem_wr_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_wr_i;
    logic [10:0] mem_req_tag_i;
    logic        mem_cacheable_i;
    logic        mem_flush_i;
    logic        mem_invalidate_i;
    logic        mem_accept_o;
    logic        mem_ack_o;
    logic        mem_error_o;
    logic [31:0] mem_data_rd_o;
    logic [10:0] mem_resp_tag_o;

    riscv_dmem_wb_bridge_if wb ();

    riscv_dmem_wb_bridge #(.TIMEOUT(TO), .TIMEOUT_W(8)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .mem_rd_i         (mem_rd_i),
        .mem_wr_i         (mem_wr_i),
        .mem_addr_i       (mem_addr_i),
        .mem_data_wr_i    (mem_data_wr_i),
        .mem_req_tag_i    (mem_req_tag_i),
        .mem_cacheable_i  (mem_cacheable_i),
        .mem_flush_i      (mem_flush_i),
        .mem_invalidate_i (mem_invalidate_i),
        .mem_accept_o     (mem_accept_o),
        .mem_ack_o        (mem_ack_o),
        .mem_error_o      (mem_error_o),
        .mem_data_rd_o    (mem_data_rd_o),
        .mem_resp_tag_o   (mem_resp_tag_o),
        .wb               (wb)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Slave response kinds
    localparam int R_NONE = 0, R_ACK = 1, R_ERR = 2, R_BOTH = 3;

    typedef struct {
        logic        rd;
        logic [3:0]  wr;
        logic        flush;
        logic        inv;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [10:0] tag;
        int          resp;
        int          waits;
        logic [31:0] sdata;
        logic        e_bus;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_adr;
        logic [31:0] e_dat;
        logic        e_err;
        logic [31:0] e_data;
        int          e_lat;
    } vec_t;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        stable;
        int          bus_cycles;
        logic        err;
        logic [31:0] data;
        logic [10:0] tag;
        int          lat;
        logic        one_shot;
        logic        acc_after;
        logic        quiet;
    } res_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_rd_i         = 1'b0;
        mem_wr_i         = 4'h0;
        mem_addr_i       = 32'h0;
        mem_data_wr_i    = 32'h0;
        mem_req_tag_i    = 11'h0;
        mem_cacheable_i  = 1'b0;
        mem_flush_i      = 1'b0;
        mem_invalidate_i = 1'b0;
    endtask

    // Reference model: what the bridge must do for one request and one slave behaviour.
    function automatic vec_t model(input vec_t v);
        vec_t e;
        logic store;
        e     = v;
        store = (v.wr != 4'h0);
        e.e_bus = !(v.flush || v.inv);
        e.e_we  = store;
        e.e_sel = store ? v.wr : 4'hF;
        e.e_adr = v.addr & 32'hFFFF_FFFC;
        e.e_dat = v.wdata;
        if (!e.e_bus) begin
            e.e_lat = 1; e.e_err = 1'b0; e.e_data = 32'h0;
        end else if (v.resp == R_NONE || v.waits > TO) begin
            e.e_lat = TO + 2; e.e_err = 1'b1; e.e_data = 32'h0;
        end else begin
            e.e_lat  = v.waits + 2;
            e.e_err  = (v.resp != R_ACK);
            e.e_data = (v.resp == R_ACK && !store) ? v.sdata : 32'h0;
        end
        return e;
    endfunction

    // Called at a negedge with the bridge idle; returns at the negedge after the ack cycle.
    task automatic run_txn(input vec_t v, output res_t r);
        int  n;
        int  k;
        bit  got;
        r.we = 0; r.sel = 0; r.adr = 0; r.dat = 0; r.stable = 1; r.bus_cycles = 0;
        r.err = 0; r.data = 0; r.tag = 0; r.lat = -1; r.one_shot = 0; r.acc_after = 0; r.quiet = 1;
        mem_rd_i         = v.rd;
        mem_wr_i         = v.wr;
        mem_flush_i      = v.flush;
        mem_invalidate_i = v.inv;
        mem_addr_i       = v.addr;
        mem_data_wr_i    = v.wdata;
        mem_req_tag_i    = v.tag;
        mem_cacheable_i  = $urandom_range(1, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        clear_inputs();
        n   = 1;
        got = 0;
        while (!got && n < 40) begin
            wb.ack_i = 1'b0;
            wb.err_i = 1'b0;
            wb.dat_i = $urandom;
            if (wb.cyc_o) begin
                if (r.bus_cycles == 0) begin
                    r.we = wb.we_o; r.sel = wb.sel_o; r.adr = wb.adr_o; r.dat = wb.dat_o;
                end else if (wb.we_o !== r.we || wb.sel_o !== r.sel ||
                             wb.adr_o !== r.adr || wb.dat_o !== r.dat) begin
                    r.stable = 0;
                end
                if (wb.stb_o !== 1'b1) r.stable = 0;
                k = r.bus_cycles;
                r.bus_cycles++;
                if (v.resp != R_NONE && k == v.waits) begin
                    wb.ack_i = (v.resp == R_ACK || v.resp == R_BOTH);
                    wb.err_i = (v.resp == R_ERR || v.resp == R_BOTH);
                    wb.dat_i = v.sdata;
                end
            end
            if (mem_accept_o !== 1'b0) r.quiet = 0;
            if (mem_ack_o === 1'b1) begin
                got   = 1;
                r.lat = n;
                r.err = mem_error_o;
                r.data = mem_data_rd_o;
                r.tag = mem_resp_tag_o;
                if (wb.cyc_o !== 1'b0) r.quiet = 0;
            end else begin
                if (mem_error_o !== 1'b0 || mem_data_rd_o !== 32'h0 || mem_resp_tag_o !== 11'h0)
                    r.quiet = 0;
                @(posedge clk_i);
                @(negedge clk_i);
                n++;
            end
        end
        wb.ack_i = 1'b0;
        wb.err_i = 1'b0;
        if (got) begin
            @(posedge clk_i);
            @(negedge clk_i);
            r.one_shot  = (mem_ack_o === 1'b0);
            r.acc_after = (mem_accept_o === 1'b1);
        end
    endtask

    task automatic compare(input string nm, input vec_t e, input res_t r);
        check({nm, "_lat"}, r.lat, e.e_lat);
        check({nm, "_bus"}, (r.bus_cycles > 0), e.e_bus);
        if (e.e_bus) begin
            check({nm, "_bus_cycles"}, r.bus_cycles, e.e_lat - 1);
            check({nm, "_we"}, r.we, e.e_we);
            check({nm, "_sel"}, r.sel, e.e_sel);
            check({nm, "_adr"}, r.adr, e.e_adr);
            check({nm, "_dat"}, r.dat, e.e_dat);
            check({nm, "_stable"}, r.stable, 1);
        end
        check({nm, "_err"}, r.err, e.e_err);
        check({nm, "_data"}, r.data, e.e_data);
        check({nm, "_tag"}, r.tag, e.tag);
        check({nm, "_one_shot"}, r.one_shot, 1);
        check({nm, "_accept_after"}, r.acc_after, 1);
        check({nm, "_quiet"}, r.quiet, 1);
    endtask

    function automatic vec_t mk(input logic rd, input logic [3:0] wr, input logic fl, input logic iv,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [10:0] tag, input int resp, input int waits,
                                input logic [31:0] sdata, input logic e_bus, input logic e_we,
                                input logic [3:0] e_sel, input logic [31:0] e_adr,
                                input logic e_err, input logic [31:0] e_data, input int e_lat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.flush = fl; v.inv = iv; v.addr = addr; v.wdata = wdata;
        v.tag = tag; v.resp = resp; v.waits = waits; v.sdata = sdata;
        v.e_bus = e_bus; v.e_we = e_we; v.e_sel = e_sel; v.e_adr = e_adr; v.e_dat = wdata;
        v.e_err = e_err; v.e_data = e_data; v.e_lat = e_lat;
        return v;
    endfunction

    vec_t vecs[10];

    initial begin
        vec_t v;
        res_t r;
        bit   clean;

        vecs[0] = mk(1, 4'h0, 0, 0, 32'h0000_1000, 32'h0, 11'h2A5, R_ACK, 2, 32'hDEAD_BEEF,
                     1, 0, 4'hF, 32'h0000_1000, 0, 32'hDEAD_BEEF, 4);
        vecs[1] = mk(0, 4'b0100, 0, 0, 32'h0000_2002, 32'h00AB_0000, 11'h011, R_ACK, 0, 32'h1234_5678,
                     1, 1, 4'b0100, 32'h0000_2000, 0, 32'h0, 2);
        vecs[2] = mk(1, 4'h0, 0, 0, 32'h0000_3000, 32'h0, 11'h155, R_NONE, 0, 32'h0,
                     1, 0, 4'hF, 32'h0000_3000, 1, 32'h0, 6);
        vecs[3] = mk(1, 4'h0, 0, 0, 32'h0000_4004, 32'h0, 11'h0AA, R_ERR, 0, 32'h0000_0055,
                     1, 0, 4'hF, 32'h0000_4004, 1, 32'h0, 2);
        vecs[4] = mk(1, 4'h0, 0, 0, 32'h0000_4008, 32'h0, 11'h0AB, R_ACK, 1, 32'hCAFE_F00D,
                     1, 0, 4'hF, 32'h0000_4008, 0, 32'hCAFE_F00D, 3);
        vecs[5] = mk(0, 4'h0, 1, 0, 32'h0000_5000, 32'h0, 11'h7FF, R_ACK, 0, 32'hFFFF_FFFF,
                     0, 0, 4'h0, 32'h0, 0, 32'h0, 1);
        vecs[6] = mk(1, 4'h0, 0, 1, 32'h0000_5004, 32'h0, 11'h123, R_ACK, 0, 32'hFFFF_FFFF,
                     0, 0, 4'h0, 32'h0, 0, 32'h0, 1);
        vecs[7] = mk(1, 4'hF, 0, 0, 32'h0000_600F, 32'hA5A5_A5A5, 11'h3C3, R_BOTH, 3, 32'h1111_1111,
                     1, 1, 4'hF, 32'h0000_600C, 1, 32'h0, 5);
        vecs[8] = mk(1, 4'h0, 0, 0, 32'h0000_7000, 32'h0, 11'h400, R_ACK, 4, 32'h0F0F_0F0F,
                     1, 0, 4'hF, 32'h0000_7000, 0, 32'h0F0F_0F0F, 6);
        vecs[9] = mk(1, 4'h0, 0, 0, 32'h0000_7004, 32'h0, 11'h401, R_ACK, 5, 32'h0F0F_0F0F,
                     1, 0, 4'hF, 32'h0000_7004, 1, 32'h0, 6);

        clear_inputs();
        wb.ack_i = 1'b0;
        wb.err_i = 1'b0;
        wb.dat_i = 32'h0;
        rst_ni   = 1'b0;
        repeat (3) @(negedge clk_i);

        check("rst_accept", mem_accept_o, 1);
        check("rst_ack", mem_ack_o, 0);
        check("rst_resp", {mem_error_o, mem_resp_tag_o}, 0);
        check("rst_rdata", mem_data_rd_o, 0);
        check("rst_bus", {wb.cyc_o, wb.stb_o, wb.we_o, wb.sel_o}, 0);
        check("rst_adr", wb.adr_o, 0);
        check("rst_dat", wb.dat_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed table, issued back to back.
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], r);
            compare($sformatf("vec%0d", i), vecs[i], r);
        end

        // Slave strobes while idle must not produce a response.
        wb.ack_i = 1'b1;
        wb.err_i = 1'b1;
        wb.dat_i = 32'hBAD0_BAD0;
        @(posedge clk_i);
        @(negedge clk_i);
        wb.ack_i = 1'b0;
        wb.err_i = 1'b0;
        check("idle_ack_ignored", mem_ack_o, 0);
        check("idle_accept", mem_accept_o, 1);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            int op;
            int rs;
            v.rd = 0; v.wr = 0; v.flush = 0; v.inv = 0;
            op = $urandom_range(7, 0);
            if (op <= 2) v.rd = 1;
            else if (op <= 5) begin
                v.wr = 4'($urandom_range(15, 1));
                v.rd = $urandom_range(1, 0);
            end else begin
                v.flush = (op == 6);
                v.inv   = (op == 7);
                v.rd    = $urandom_range(1, 0);
                v.wr    = 4'($urandom_range(15, 0));
            end
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.tag   = 11'($urandom);
            v.sdata = $urandom;
            rs      = $urandom_range(7, 0);
            v.resp  = (rs <= 4) ? R_ACK : (rs == 5) ? R_ERR : (rs == 6) ? R_BOTH : R_NONE;
            v.waits = $urandom_range(6, 0);
            v = model(v);
            run_txn(v, r);
            compare($sformatf("rnd%0d", i), v, r);
        end

        // Reset in the middle of a bus cycle drops the op without an ack.
        mem_rd_i      = 1'b1;
        mem_addr_i    = 32'h0000_8000;
        mem_req_tag_i = 11'h055;
        @(posedge clk_i);
        @(negedge clk_i);
        clear_inputs();
        check("midbus_cyc", wb.cyc_o, 1);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_async_cyc", {wb.cyc_o, wb.stb_o}, 0);
        check("rst_async_ack", mem_ack_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        clean = 1;
        for (int i = 0; i < 8; i++) begin
            wb.ack_i = 1'b1;
            wb.dat_i = 32'h5555_AAAA;
            @(negedge clk_i);
            if (mem_ack_o !== 1'b0 || mem_accept_o !== 1'b1 || wb.cyc_o !== 1'b0) clean = 0;
        end
        wb.ack_i = 1'b0;
        check("rst_no_stale_ack", clean, 1);

        // Bridge is usable again after the reset.
        run_txn(vecs[0], r);
        compare("post_rst", vecs[0], r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
